// File: rtl/arb_pkg.sv
// Shared constants and helpers for the 2-D pixel arbiter.
package arb_pkg;

    localparam int unsigned DEF_ROWS = 8;
    localparam int unsigned DEF_COLS = 8;

    localparam logic [1:0] POL_ON  = 2'b10;
    localparam logic [1:0] POL_OFF = 2'b01;

    // Index width for an N-entry vector; never below 1 bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);

    always_comb begin
        logic        found;
        int unsigned k;
        found = 1'b0;
        k     = 0;
        gnt   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req[W'(k)]) begin
                found       = 1'b1;
                gnt[W'(k)]  = 1'b1;
                idx         = W'(k);
            end
        end
    end

endmodule

// File: rtl/top_arb_2d.sv
// Two-dimensional round-robin pixel arbiter with registered one-hot row/column grants.
// Optional ARB_GNT_VALID_EN adds a registered gnt_valid_o output.
module top_arb_2d
    import arb_pkg::*;
#(
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned COLS     = DEF_COLS,
    parameter int unsigned POLARITY = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic [COLS-1:0][POLARITY-1:0] req_i [ROWS-1:0],
    output logic [ROWS-1:0]               x_gnt_o,
    output logic [COLS-1:0]               y_gnt_o,
    output logic                          polarity_o
`ifdef ARB_GNT_VALID_EN
    ,
    output logic                          gnt_valid_o
`endif
);

    localparam int unsigned RW = idx_width(ROWS);
    localparam int unsigned CW = idx_width(COLS);

    logic [RW-1:0]                 rp_q, rp_d, row_idx;
    logic [CW-1:0]                 cp_q, cp_d, col_idx;
    logic [ROWS-1:0]               row_act, row_gnt, x_gnt_q;
    logic [COLS-1:0]               col_act, col_gnt, y_gnt_q;
    logic [COLS-1:0][POLARITY-1:0] sel_row;
    logic                          grant, pol_d, pol_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row_act
        assign row_act[r] = |req_i[r];
    end

    rr_arbiter #(.N(ROWS)) u_row_arb (
        .req (row_act),
        .ptr (rp_q),
        .gnt (row_gnt),
        .idx (row_idx)
    );

    assign sel_row = req_i[row_idx];

    for (genvar c = 0; c < COLS; c++) begin : g_col_act
        assign col_act[c] = |sel_row[c];
    end

    rr_arbiter #(.N(COLS)) u_col_arb (
        .req (col_act),
        .ptr (cp_q),
        .gnt (col_gnt),
        .idx (col_idx)
    );

    // A pixel with both bits set reports ON; OFF is the lower-priority event.
    assign pol_d = |(sel_row[col_idx] & POL_ON);
    assign grant = enable_i & (|row_act);
    assign rp_d  = (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
    assign cp_d  = (col_idx == CW'(COLS - 1)) ? '0 : col_idx + CW'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            x_gnt_q <= '0;
            y_gnt_q <= '0;
            pol_q   <= 1'b0;
            rp_q    <= '0;
            cp_q    <= '0;
        end else if (grant) begin
            x_gnt_q <= row_gnt;
            y_gnt_q <= col_gnt;
            pol_q   <= pol_d;
            rp_q    <= rp_d;
            cp_q    <= cp_d;
        end else begin
            x_gnt_q <= '0;
            y_gnt_q <= '0;
            pol_q   <= 1'b0;
        end
    end

    assign x_gnt_o    = x_gnt_q;
    assign y_gnt_o    = y_gnt_q;
    assign polarity_o = pol_q;

`ifdef ARB_GNT_VALID_EN
    logic valid_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= grant;
        end
    end

    assign gnt_valid_o = valid_q;
`endif

endmodule

// File: tb/tb_top_arb_2d.sv
// Bench for top_arb_2d: behavioural round-robin model checked every cycle plus directed literals.
module tb_top_arb_2d;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic                 clk    = 1'b0;
    logic                 reset  = 1'b1;
    logic                 enable = 1'b0;
    logic [COLS-1:0][1:0] req [ROWS-1:0];
    logic [ROWS-1:0]      x_gnt;
    logic [COLS-1:0]      y_gnt;
    logic                 pol;
`ifdef ARB_GNT_VALID_EN
    logic                 gnt_valid;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // Model state: expected outputs and the two rotation pointers.
    logic [ROWS-1:0] m_x   = '0;
    logic [COLS-1:0] m_y   = '0;
    logic            m_pol = 1'b0;
    int              m_rp  = 0;
    int              m_cp  = 0;

    always #5 clk = ~clk;

    top_arb_2d #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .POLARITY (2)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .enable_i   (enable),
        .req_i      (req),
        .x_gnt_o    (x_gnt),
        .y_gnt_o    (y_gnt),
        .polarity_o (pol)
`ifdef ARB_GNT_VALID_EN
        ,
        .gnt_valid_o (gnt_valid)
`endif
    );

    // Model: search rows from rp, then pixels of that row from cp, both modulo.
    always @(posedge clk or posedge reset) begin
        int r, c, k;
        if (reset) begin
            m_x   <= '0;
            m_y   <= '0;
            m_pol <= 1'b0;
            m_rp  <= 0;
            m_cp  <= 0;
        end else begin
            r = -1;
            c = -1;
            if (enable) begin
                for (int i = 0; i < ROWS; i++) begin
                    k = (m_rp + i) % ROWS;
                    if (r < 0 && req[k] != '0) r = k;
                end
            end
            if (r >= 0) begin
                for (int j = 0; j < COLS; j++) begin
                    k = (m_cp + j) % COLS;
                    if (c < 0 && req[r][k] != 2'b00) c = k;
                end
                m_x   <= 8'b1 << r;
                m_y   <= 8'b1 << c;
                m_pol <= req[r][c][1];
                m_rp  <= (r + 1) % ROWS;
                m_cp  <= (c + 1) % COLS;
            end else begin
                m_x   <= '0;
                m_y   <= '0;
                m_pol <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic bad;
        bad = (x_gnt !== m_x) || (y_gnt !== m_y) || (pol !== m_pol);
`ifdef ARB_GNT_VALID_EN
        bad = bad || (gnt_valid !== (|m_x));
`endif
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL model @%0t: got x=%h y=%h pol=%b, want x=%h y=%h pol=%b",
                     $time, x_gnt, y_gnt, pol, m_x, m_y, m_pol);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, got, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] x, input logic [7:0] y,
                             input logic p);
        check({name, ".x"}, 32'(x_gnt), 32'(x));
        check({name, ".y"}, 32'(y_gnt), 32'(y));
        check({name, ".pol"}, 32'(pol), 32'(p));
`ifdef ARB_GNT_VALID_EN
        check({name, ".valid"}, 32'(gnt_valid), 32'(|x));
`endif
    endtask

    task automatic expect_grant(input string name, input logic [7:0] x, input logic [7:0] y,
                                input logic p);
        @(negedge clk);
        check_out(name, x, y, p);
    endtask

    task automatic clear_req();
        for (int r = 0; r < ROWS; r++) req[r] = '0;
    endtask

    initial begin
        clear_req();
        @(negedge clk);
        check_out("reset", 8'h00, 8'h00, 1'b0);

        // Released but disabled: row 0 requesting must not be granted.
        req[0][7] = 2'b10; req[0][6] = 2'b01; req[0][4] = 2'b01;
        req[0][2] = 2'b10; req[0][1] = 2'b10; req[0][0] = 2'b01;
        reset = 1'b0;
        expect_grant("disabled0", 8'h00, 8'h00, 1'b0);
        expect_grant("disabled1", 8'h00, 8'h00, 1'b0);

        enable = 1'b1;
        expect_grant("row0_c0", 8'h01, 8'h01, 1'b0);
        expect_grant("row0_c1", 8'h01, 8'h02, 1'b1);
        expect_grant("row0_c2", 8'h01, 8'h04, 1'b1);
        expect_grant("row0_c4", 8'h01, 8'h10, 1'b0);
        expect_grant("row0_c6", 8'h01, 8'h40, 1'b0);
        expect_grant("row0_c7", 8'h01, 8'h80, 1'b1);
        expect_grant("row0_wrap", 8'h01, 8'h01, 1'b0);

        clear_req();
        req[1][2] = 2'b10;
        req[6][2] = 2'b10;
        expect_grant("alt_r1a", 8'h02, 8'h04, 1'b1);
        expect_grant("alt_r6a", 8'h40, 8'h04, 1'b1);
        expect_grant("alt_r1b", 8'h02, 8'h04, 1'b1);
        expect_grant("alt_r6b", 8'h40, 8'h04, 1'b1);

        clear_req();
        req[2][5] = 2'b11;
        for (int i = 0; i < 3; i++) expect_grant("both_pol", 8'h04, 8'h20, 1'b1);

        clear_req();
        req[3][6] = 2'b01;
        req[3][2] = 2'b10;
        req[5][1] = 2'b10;
        expect_grant("pre_rst0", 8'h08, 8'h40, 1'b0);
        expect_grant("pre_rst1", 8'h20, 8'h02, 1'b1);
        #2 reset = 1'b1;
        #1 check_out("async_rst", 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        expect_grant("post_rst", 8'h08, 8'h04, 1'b1);

        enable = 1'b0;
        expect_grant("drop_en0", 8'h00, 8'h00, 1'b0);
        expect_grant("drop_en1", 8'h00, 8'h00, 1'b0);
        enable = 1'b1;
        expect_grant("resume0", 8'h20, 8'h02, 1'b1);
        expect_grant("resume1", 8'h08, 8'h04, 1'b1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/top_arb_2d.md
# top_arb_2d

Two-dimensional round-robin arbiter for the event-based pixel array. It takes one multi-bit polarity request per pixel of a ROWS×COLS array and each cycle selects at most one requesting pixel. The selected pixel is reported as a one-hot row grant, a one-hot column grant and the pixel's event polarity. It sits between the pixel array and the address-event encoder; requests are level-sensitive and are cleared by the pixel, not by this block.

## Interface
- ROWS, default 8: pixel rows, must be ≥2.
- COLS, default 8: pixel columns, must be ≥2.
- POLARITY, default 2: polarity bits per pixel. Bit 1 is the ON event and bit 0 is the OFF event. Only the value 2 is supported.
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  reset, asynchronous and active-high.
- enable_i  in  1  arbitration enable.
- req_i  in  unpacked [ROWS-1:0] of packed [COLS-1:0][POLARITY-1:0]  per-pixel requests; req_i[r][c] is pixel (r,c).
- x_gnt_o  out  ROWS  one-hot granted row, or all zero.
- y_gnt_o  out  COLS  one-hot granted column, or all zero.
- polarity_o  out  1  polarity of the granted event: 1 = ON, 0 = OFF.

## Operation
- A pixel is active when |req_i[r][c] is 1. A row is active when any of its pixels is active.
- Row stage: round-robin over active rows, starting the search at row pointer rp and wrapping from ROWS-1 to 0.
- Column stage: round-robin over the active pixels of the selected row, starting at column pointer cp and wrapping from COLS-1 to 0. There is one cp shared by all rows.
- Polarity: polarity_o = req_i[r][c][1].
  - 2'b10 → 1.
  - 2'b01 → 0.
  - 2'b11 → 1; the ON event is reported first.
- Pointer update on each grant of pixel (r,c):
  - rp ← (r+1) mod ROWS.
  - cp ← (c+1) mod COLS.
- When enable_i=0, or no pixel is active:
  - All outputs go to 0 on the next edge.
  - rp and cp hold.
- Requests that persist are re-granted whenever the rotation reaches them. This block never masks a request.

## Timing
- Reset values:
  - x_gnt_o=0, y_gnt_o=0, polarity_o=0.
  - rp=0, cp=0, so index 0 has highest priority after reset.
- Latency is one cycle. Outputs are registered and reflect req_i and enable_i sampled at the preceding rising edge.
- One new grant is issued per cycle while enabled and requests exist. There is no handshake.
- x_gnt_o and y_gnt_o are either both zero or both one-hot.
- Asserting reset_i mid-stream clears the outputs and pointers immediately, without waiting for a clock edge.
- A request that changes in the same cycle as a grant takes effect at the next edge.

## Configuration
- ARB_GNT_VALID_EN: when defined, adds output gnt_valid_o (1 bit, registered).
  - gnt_valid_o = |x_gnt_o.
  - Reset value is 0.
- Without ARB_GNT_VALID_EN the port does not exist. Behaviour is otherwise identical.

## Structure
- Package arb_pkg holds:
  - Default ROWS/COLS constants.
  - Polarity encodings POL_ON=2'b10 and POL_OFF=2'b01.
  - An index-width function (clog2).
- Sub-module rr_arbiter #(N) is combinational:
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt and binary idx.
- rr_arbiter is instantiated once for rows and once for columns. The top level holds the registers and the pointer logic.

## Test plan
- Reset asserted → all outputs 0. Releasing reset with enable_i=0 and row 0 requesting → outputs stay 0.
- enable_i=1; row 0 columns 7:10, 6:01, 4:01, 2:10, 1:10, 0:01; other rows 0 → successive cycles give:
  - x=8'h01 every cycle.
  - y sequence 01/pol 0, 02/1, 04/1, 10/0, 40/0, 80/1, then wraps to 01.
- Rows 1 and 6 each request column 2 with 2'b10 → x alternates 8'h02, 8'h40; y stays 8'h04 and polarity_o stays 1.
- Pixel (2,5)=2'b11 alone → x=8'h04, y=8'h20, polarity_o=1 on every cycle.
- Reset pulse mid-rotation → outputs 0 at once. The first grant afterwards goes to the lowest-index active row and column.
- enable_i dropped while requests remain → outputs 0 after one edge. Re-enabling resumes from the held pointers.
